// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: state, opcode and mux-select encodings for the multi-cycle MIPS control sequencer.
package mips_mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_BRANCH, S_JUMP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALUSRCB_B     = 2'd0;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'd1;
  localparam logic [1:0] ALUSRCB_IMM   = 2'd2;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'd3;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;
  localparam logic [1:0] WBSRC_ALUOUT = 2'd0;
  localparam logic [1:0] WBSRC_MDR    = 2'd1;
  localparam logic [1:0] WBSRC_PC     = 2'd2;
  // Unsupported opcodes fall back to FETCH.
  function automatic state_t dispatch(input logic [5:0] op);
    return op == OP_RTYPE ? S_EXEC_R :
           (op == OP_LW || op == OP_SW) ? S_MEM_ADDR :
           (op == OP_BEQ || op == OP_BNE) ? S_BRANCH :
           op == OP_ADDI ? S_EXEC_I :
           (op == OP_J || op == OP_JAL) ? S_JUMP : S_FETCH;
  endfunction
  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JAL};
  endfunction
endpackage

// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle MIPS main control FSM with ready-handshaked memory accesses.
module mips_mc_control
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op
);
  state_t state, next;
  logic [5:0] op;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      op    <= OP_RTYPE;
    end else begin
      state <= next;
      if (state == S_DECODE) op <= opcode;
    end
  end
  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:    next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   next = dispatch(opcode);
      S_MEM_ADDR: next = op == OP_SW ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   next = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   next = S_WB_R;
      S_EXEC_I:   next = S_WB_I;
      default:    next = S_FETCH;
    endcase
  end
  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    reg_dst    = REGDST_RT;
    mem_to_reg = WBSRC_ALUOUT;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUSRCB_B;
    alu_op     = ALU_OP_ADD;
    pc_source  = PCSRC_ALU;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUSRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = ALUSRCB_IMMSH;
        illegal_op = !is_legal(opcode);
      end
      S_MEM_ADDR, S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUSRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read  = 1'b1;
        iord      = 1'b1;
        mdr_write = mem_ready;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = WBSRC_MDR;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = REGDST_RD;
      end
      S_WB_I: reg_write = 1'b1;
      // bne inverts the sense of the zero flag
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = alu_zero ^ (op == OP_BNE);
      end
      S_JUMP: begin
        pc_source  = PCSRC_JUMP;
        pc_write   = 1'b1;
        reg_write  = op == OP_JAL;
        reg_dst    = op == OP_JAL ? REGDST_RA : REGDST_RT;
        mem_to_reg = op == OP_JAL ? WBSRC_PC : WBSRC_ALUOUT;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: per-cycle vector check of the control sequencer against an instruction-level model.
module tb_mips_mc_control;
  typedef struct packed {
    logic       pc_write, iord, mem_read, mem_write, ir_write, mdr_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op;
  } outs_t;
  typedef struct {
    string      tag;
    logic [5:0] opc;
    logic       rdy;
    logic       z;
    outs_t      exp;
  } vec_t;

  logic clk = 0, rst = 1;
  logic [5:0] opcode = 0;
  logic alu_zero = 0, mem_ready = 0;
  logic pc_write, iord, mem_read, mem_write, ir_write, mdr_write, reg_write, alu_src_a, illegal_op;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  outs_t act;
  int nvec = 0, nerr = 0;
  vec_t q[$];

  always #5 clk = ~clk;

  mips_mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mdr_write(mdr_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op)
  );

  assign act = {pc_write, iord, mem_read, mem_write, ir_write, mdr_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  task automatic chk(input string tag, input outs_t e);
    nvec++;
    if (act !== e) begin
      nerr++;
      $display("FAIL %s @%0t: got %b want %b", tag, $time, act, e);
    end
  endtask

  task automatic add(input string tag, input logic [5:0] opc, input logic rdy, input logic z, input outs_t e);
    vec_t v;
    v.tag = tag; v.opc = opc; v.rdy = rdy; v.z = z; v.exp = e;
    q.push_back(v);
  endtask

  function automatic outs_t idle_fetch();
    outs_t e = '0;
    e.mem_read = 1; e.alu_src_b = 1;
    return e;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction; opcode is scrambled after decode.
  task automatic gen(input logic [5:0] op, input int fw, input int mw, input logic z);
    outs_t e;
    bit legal = op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h03};
    for (int i = 0; i < fw; i++) add("fetch_wait", 6'($urandom), 0, 1'($urandom), idle_fetch());
    e = idle_fetch(); e.ir_write = 1; e.pc_write = 1;
    add("fetch", 6'($urandom), 1, 1'($urandom), e);
    e = '0; e.alu_src_b = 3; e.illegal_op = !legal;
    add("decode", op, 1'($urandom), 1'($urandom), e);
    if (op == 6'h00) begin
      e = '0; e.alu_src_a = 1; e.alu_op = 2;
      add("exec_r", 6'($urandom), 1'($urandom), 1'($urandom), e);
      e = '0; e.reg_write = 1; e.reg_dst = 1;
      add("wb_r", 6'($urandom), 1'($urandom), 1'($urandom), e);
    end else if (op == 6'h08 || op == 6'h23 || op == 6'h2B) begin
      e = '0; e.alu_src_a = 1; e.alu_src_b = 2;
      add(op == 6'h08 ? "exec_i" : "mem_addr", 6'($urandom), 1'($urandom), 1'($urandom), e);
      if (op == 6'h08) begin
        e = '0; e.reg_write = 1;
        add("wb_i", 6'($urandom), 1'($urandom), 1'($urandom), e);
      end else begin
        e = '0; e.iord = 1; e.mem_read = op == 6'h23; e.mem_write = op == 6'h2B;
        for (int i = 0; i < mw; i++) add("mem_wait", 6'($urandom), 0, 1'($urandom), e);
        e.mdr_write = op == 6'h23;
        add("mem_done", 6'($urandom), 1, 1'($urandom), e);
        if (op == 6'h23) begin
          e = '0; e.reg_write = 1; e.mem_to_reg = 1;
          add("mem_wb", 6'($urandom), 1'($urandom), 1'($urandom), e);
        end
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      e = '0; e.alu_src_a = 1; e.alu_op = 1; e.pc_source = 1;
      e.pc_write = op == 6'h04 ? z : !z;
      add("branch", 6'($urandom), 1'($urandom), z, e);
    end else if (op == 6'h02 || op == 6'h03) begin
      e = '0; e.pc_source = 2; e.pc_write = 1;
      if (op == 6'h03) begin e.reg_write = 1; e.reg_dst = 2; e.mem_to_reg = 2; end
      add("jump", 6'($urandom), 1'($urandom), 1'($urandom), e);
    end
  endtask

  // Entered #1 after a rising edge; leaves the same way.
  task automatic run();
    foreach (q[i]) begin
      opcode = q[i].opc; mem_ready = q[i].rdy; alu_zero = q[i].z;
      @(negedge clk);
      chk(q[i].tag, q[i].exp);
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  initial begin
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h03};
    #2;
    chk("reset", idle_fetch());
    @(posedge clk); #1;
    rst = 0;
    // directed instructions
    gen(6'h00, 0, 0, 0);
    gen(6'h23, 2, 2, 0);
    gen(6'h2B, 0, 1, 0);
    gen(6'h04, 0, 0, 1);
    gen(6'h04, 1, 0, 0);
    gen(6'h05, 0, 0, 1);
    gen(6'h05, 0, 0, 0);
    gen(6'h03, 0, 0, 0);
    gen(6'h02, 0, 0, 0);
    gen(6'h08, 0, 0, 0);
    gen(6'h3F, 0, 0, 0);
    run();
    // randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      gen(op, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end
    run();
    // reset while a store is waiting on memory
    gen(6'h2B, 0, 1, 0);
    void'(q.pop_back());
    run();
    mem_ready = 0;
    #2;
    chk("mem_wr_before_rst", outs_t'(19'b0101000000000000000));
    rst = 1;
    #1;
    chk("rst_same_cycle", idle_fetch());
    @(negedge clk);
    chk("rst_held", idle_fetch());
    @(posedge clk); #1;
    chk("rst_after_edge", idle_fetch());
    rst = 0;
    gen(6'h08, 1, 0, 0);
    run();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
